// File: rtl/alu_pkg.sv
// Shared op codes, op-field positions and FSM state encoding for the sequential ALU.
package alu_pkg;

  localparam int OP_W     = 4;
  localparam int AINV_POS = 3;
  localparam int BNEG_POS = 2;
  localparam int SEL_HI   = 1;
  localparam int SEL_LO   = 0;

  localparam logic [OP_W-1:0] OP_AND = 4'b0000;
  localparam logic [OP_W-1:0] OP_OR  = 4'b0001;
  localparam logic [OP_W-1:0] OP_ADD = 4'b0010;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0110;
  localparam logic [OP_W-1:0] OP_SLT = 4'b0111;
  localparam logic [OP_W-1:0] OP_NOR = 4'b1100;
  localparam logic [OP_W-1:0] OP_MUL = 4'b1000;

  localparam logic [1:0] SEL_AND  = 2'b00;
  localparam logic [1:0] SEL_OR   = 2'b01;
  localparam logic [1:0] SEL_SUM  = 2'b10;
  localparam logic [1:0] SEL_LESS = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_bit_slice.sv
// One bit of the ALU: optional operand inversion, full adder and a 4-way result select.
module alu_bit_slice
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       carryIn,
  input  logic       ainvert,
  input  logic       binvert,
  input  logic       less,
  input  logic [1:0] sel,
  output logic       result,
  output logic       carryOut
);

  logic a_eff;
  logic b_eff;
  logic sum;

  // Carry path kept apart from the result mux so that feeding 'less' back into slice 0 forms no loop
  assign a_eff    = a ^ ainvert;
  assign b_eff    = b ^ binvert;
  assign sum      = a_eff ^ b_eff ^ carryIn;
  assign carryOut = (a_eff & b_eff) | (carryIn & (a_eff ^ b_eff));

  always_comb begin
    result = 1'b0;
    case (sel)
      SEL_AND:  result = a_eff & b_eff;
      SEL_OR:   result = a_eff | b_eff;
      SEL_SUM:  result = sum;
      SEL_LESS: result = less;
      default:  result = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_nbit_seq.sv
// Registered WIDTH-bit ALU on a chain of bit slices, with a multi-cycle shift-add multiplier
// and valid/ready handshakes on both sides.
module alu_nbit_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [3:0]       op,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] result,
  output logic             carryOut,
  output logic             overflow,
  output logic             zero,
  output logic             err
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic       ainvert;
  logic       bnegate;
  logic [1:0] sel;

  assign ainvert = op[AINV_POS];
  assign bnegate = op[BNEG_POS];
  assign sel     = op[SEL_HI:SEL_LO];

  logic [WIDTH-1:0] slice_res;
  logic             msb_cin;
  logic             msb_cout;
  logic             msb_sum;
  logic             ovf_raw;
  logic             set_less;

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    logic c_in;
    logic c_out;
    if (i == 0) begin : g_first
      assign c_in = bnegate;
    end else begin : g_rest
      assign c_in = g_slice[i-1].c_out;
    end
    alu_bit_slice u_slice (
      .a        (in1[i]),
      .b        (in2[i]),
      .carryIn  (c_in),
      .ainvert  (ainvert),
      .binvert  (bnegate),
      .less     ((i == 0) ? set_less : 1'b0),
      .sel      (sel),
      .result   (slice_res[i]),
      .carryOut (c_out)
    );
  end

  // SLT uses the MSB sum corrected by overflow so the signed compare stays right when a-b wraps
  assign msb_cin  = g_slice[WIDTH-1].c_in;
  assign msb_cout = g_slice[WIDTH-1].c_out;
  assign msb_sum  = (in1[WIDTH-1] ^ ainvert) ^ (in2[WIDTH-1] ^ bnegate) ^ msb_cin;
  assign ovf_raw  = msb_cin ^ msb_cout;
  assign set_less = msb_sum ^ ovf_raw;

  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             alu_ovf;
  logic             alu_err;

  always_comb begin
    alu_res   = slice_res;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_err   = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        alu_carry = msb_cout;
        alu_ovf   = ovf_raw;
      end
      OP_SLT:                 alu_carry = msb_cout;
      OP_AND, OP_OR, OP_NOR:  alu_carry = 1'b0;
      default: begin
        alu_res = '0;
        alu_err = 1'b1;
      end
    endcase
  end

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [CNT_W-1:0] cnt;
  logic             is_mul;
  logic             accept;
  logic             load_alu;
  logic             load_mul;
  logic             start_mul;
  logic             out_valid_next;

  assign is_mul   = (op == OP_MUL) && (MUL_EN != 0);
  assign acc_next = mul_b[0] ? (acc + mul_a) : acc;

  always_comb begin
    next_state     = state;
    load_alu       = 1'b0;
    load_mul       = 1'b0;
    start_mul      = 1'b0;
    inReady        = (state == IDLE) && (!outValid || outReady) && !rst;
    accept         = inValid && inReady;
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_mul) begin
            start_mul  = 1'b1;
            next_state = MUL;
          end else begin
            load_alu = 1'b1;
          end
        end
      end
      MUL: begin
        if (cnt == CNT_LAST) begin
          load_mul   = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
    // A fresh load wins over a consumer handshake in the same cycle
    out_valid_next = outValid;
    if (load_alu || load_mul) begin
      out_valid_next = 1'b1;
    end else if (outReady) begin
      out_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      outValid <= 1'b0;
      result   <= '0;
      carryOut <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= next_state;
      outValid <= out_valid_next;
      if (load_alu) begin
        result   <= alu_res;
        carryOut <= alu_carry;
        overflow <= alu_ovf;
        zero     <= (alu_res == '0);
        err      <= alu_err;
      end else if (load_mul) begin
        result   <= acc_next;
        carryOut <= 1'b0;
        overflow <= 1'b0;
        zero     <= (acc_next == '0);
        err      <= 1'b0;
      end
    end
  end

  // Shift-add multiplier: one multiplier bit per cycle, product kept mod 2^WIDTH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_a <= '0;
      mul_b <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else if (start_mul) begin
      mul_a <= in1;
      mul_b <= in2;
      acc   <= '0;
      cnt   <= '0;
    end else if (state == MUL) begin
      acc   <= acc_next;
      mul_a <= mul_a << 1;
      mul_b <= mul_b >> 1;
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_nbit_seq.sv
// Scoreboard bench for alu_nbit_seq: directed vectors push expected responses, a monitor pops on each output handshake.
module tb_alu_nbit_seq;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             inValid;
  logic             inReady;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [3:0]       op;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] result;
  logic             carryOut;
  logic             overflow;
  logic             zero;
  logic             err;

  alu_nbit_seq #(.WIDTH(WIDTH), .MUL_EN(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .inValid  (inValid),
    .inReady  (inReady),
    .in1      (in1),
    .in2      (in2),
    .op       (op),
    .outValid (outValid),
    .outReady (outReady),
    .result   (result),
    .carryOut (carryOut),
    .overflow (overflow),
    .zero     (zero),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             c;
    logic             o;
    logic             z;
    logic             e;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic exp_t mk(input logic [WIDTH-1:0] r, input logic c, input logic o,
                              input logic z, input logic e);
    exp_t x;
    x.res = r;
    x.c   = c;
    x.o   = o;
    x.z   = z;
    x.e   = e;
    return x;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Monitor: every output handshake consumes one expected entry
  always @(negedge clk) begin
    exp_t e;
    if (!rst && outValid && outReady) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_output: got result %0h want no output", result);
      end else begin
        e = exp_q.pop_front();
        check_output("result",   32'(result),   32'(e.res));
        check_output("carryOut", 32'(carryOut), 32'(e.c));
        check_output("overflow", 32'(overflow), 32'(e.o));
        check_output("zero",     32'(zero),     32'(e.z));
        check_output("err",      32'(err),      32'(e.e));
      end
    end
  end

  task automatic apply_stimulus(input logic [3:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input exp_t e, input bit expect_out, output int waited);
    logic rdy;
    inValid = 1'b1;
    op      = o;
    in1     = a;
    in2     = b;
    waited  = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      rdy = inReady;
      @(posedge clk);
      #1;
      if (rdy) begin
        if (expect_out) exp_q.push_back(e);
        inValid = 1'b0;
        return;
      end
      waited++;
    end
    total++;
    bad++;
    $display("[TB] FAIL accept_timeout: got no inReady want accept within 50 cycles");
    inValid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    int lat;
    int low;
    int seen;

    rst      = 1'b1;
    inValid  = 1'b0;
    outReady = 1'b1;
    in1      = '0;
    in2      = '0;
    op       = 4'b0000;

    @(negedge clk);
    check_output("rst_inReady",  32'(inReady),  32'd0);
    check_output("rst_outValid", 32'(outValid), 32'd0);
    check_output("rst_result",   32'(result),   32'd0);
    check_output("rst_zero",     32'(zero),     32'd0);
    check_output("rst_err",      32'(err),      32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_cycles(1);

    apply_stimulus(4'b0010, 8'h7F, 8'h01, mk(8'h80, 1'b0, 1'b1, 1'b0, 1'b0), 1'b1, w);
    @(negedge clk);
    check_output("add_latency", 32'(outValid), 32'd1);
    @(posedge clk);
    #1;

    apply_stimulus(4'b0110, 8'h05, 8'h05, mk(8'h00, 1'b1, 1'b0, 1'b1, 1'b0), 1'b1, w);
    apply_stimulus(4'b1100, 8'h0F, 8'h30, mk(8'hC0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1, w);
    apply_stimulus(4'b0111, 8'h80, 8'h01, mk(8'h01, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1, w);
    apply_stimulus(4'b0111, 8'h7F, 8'h80, mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b0), 1'b1, w);
    apply_stimulus(4'b0000, 8'hF0, 8'h3C, mk(8'h30, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1, w);
    apply_stimulus(4'b0001, 8'hF0, 8'h0F, mk(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1, w);
    apply_stimulus(4'b0010, 8'hFF, 8'h01, mk(8'h00, 1'b1, 1'b0, 1'b1, 1'b0), 1'b1, w);

    apply_stimulus(4'b1000, 8'd13, 8'd11, mk(8'h8F, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1, w);
    lat = 0;
    low = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (outValid) break;
      if (!inReady) low++;
      lat++;
    end
    check_output("mul_latency",     32'(lat), 32'd8);
    check_output("mul_inReady_low", 32'(low), 32'd8);
    @(posedge clk);
    #1;

    apply_stimulus(4'b1000, 8'hFF, 8'h02, mk(8'hFE, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1, w);
    idle_cycles(12);

    outReady = 1'b0;
    apply_stimulus(4'b0010, 8'h01, 8'h02, mk(8'h03, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1, w);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_output("bp_outValid", 32'(outValid), 32'd1);
      check_output("bp_result",   32'(result),   32'h03);
      check_output("bp_zero",     32'(zero),     32'd0);
      check_output("bp_inReady",  32'(inReady),  32'd0);
      @(posedge clk);
      #1;
    end
    outReady = 1'b1;
    apply_stimulus(4'b0000, 8'h0F, 8'h3C, mk(8'h0C, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1, w);
    check_output("bp_same_cycle_accept", 32'(w), 32'd0);
    @(negedge clk);
    check_output("bp_and_valid",  32'(outValid), 32'd1);
    check_output("bp_and_result", 32'(result),   32'h0C);
    @(posedge clk);
    #1;

    apply_stimulus(4'b1000, 8'h03, 8'h05, mk(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, w);
    idle_cycles(3);
    rst = 1'b1;
    @(negedge clk);
    check_output("midmul_rst_outValid", 32'(outValid), 32'd0);
    check_output("midmul_rst_inReady",  32'(inReady),  32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (outValid) seen++;
    end
    check_output("midmul_no_output", 32'(seen), 32'd0);
    check_output("post_rst_inReady", 32'(inReady), 32'd1);
    @(posedge clk);
    #1;

    apply_stimulus(4'b1111, 8'h12, 8'h34, mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b1), 1'b1, w);

    for (int k = 0; k < 20; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check_output("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
